// File: rtl/booth_result_reader.sv
// ---------------------------------------------------------------------------
// booth_result_reader
//
// Reads the Booth multiplier's result off the shared outbus. When the control
// unit pulses start, the block strobes oe_a for one cycle (capturing A as the
// high byte), then oe_q for one cycle (capturing Q as the low byte), and then
// presents the assembled {A,Q} product on a valid/ready handshake.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   start    in   1-cycle pulse: product is ready in A:Q
//   obus     in   [WIDTH-1:0] shared outbus
//   oe_a     out  output enable to A (one cycle)
//   oe_q     out  output enable to Q (one cycle, after oe_a)
//   prod     out  [2*WIDTH-1:0] assembled product {A,Q}
//   prod_neg out  sign bit of prod
//   valid    out  prod is available to the consumer
//   ready    in   consumer accepts prod when valid && ready
//   busy     out  high in every state except IDLE
// ---------------------------------------------------------------------------
module booth_result_reader #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     obus,
    output logic                 oe_a,
    output logic                 oe_q,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 prod_neg,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRV_A = 2'd1,
        DRV_Q = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   hi_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               oe_a_q;
    logic               oe_q_q;
    logic               valid_q;
    logic               busy_q;

    // Strobes and flags are registered alongside the state so they are
    // glitch-free; the async reset clears them immediately, which releases
    // the bus as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            prod_q  <= '0;
            oe_a_q  <= 1'b0;
            oe_q_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DRV_A;
                        oe_a_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                DRV_A: begin
                    hi_q    <= obus;
                    state_q <= DRV_Q;
                    oe_a_q  <= 1'b0;
                    oe_q_q  <= 1'b1;
                end
                DRV_Q: begin
                    prod_q  <= {hi_q, obus};
                    state_q <= OUT;
                    oe_q_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
                OUT: begin
                    // Handshake; a start in the same cycle chains straight
                    // into the next read with no IDLE bubble.
                    if (ready) begin
                        valid_q <= 1'b0;
                        if (start) begin
                            state_q <= DRV_A;
                            oe_a_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_a_q  <= 1'b0;
                    oe_q_q  <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oe_a     = oe_a_q;
    assign oe_q     = oe_q_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign prod     = prod_q;
    assign prod_neg = prod_q[2*WIDTH-1];

endmodule

// File: tb/tb_booth_result_reader.sv
module tb_booth_result_reader;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           ready;
    logic [W-1:0]   obus;
    logic           oe_a, oe_q, valid, busy, prod_neg;
    logic [2*W-1:0] prod;

    // Register models: A and Q drive the bus only while enabled; otherwise
    // the bus carries random junk so a mistimed capture shows up in prod.
    logic [W-1:0] a_val, q_val, junk;

    int checks = 0;
    int errors = 0;
    int oe_a_cnt = 0;
    int oe_q_cnt = 0;
    int contention_cnt = 0;

    assign obus = oe_a ? a_val : (oe_q ? q_val : junk);

    booth_result_reader #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .obus     (obus),
        .oe_a     (oe_a),
        .oe_q     (oe_q),
        .prod     (prod),
        .prod_neg (prod_neg),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) junk = W'($urandom);

    // Strobe counters and bus contention monitor.
    always @(posedge clk) begin
        if (oe_a) oe_a_cnt++;
        if (oe_q) oe_q_cnt++;
        if (oe_a && oe_q) contention_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference product: A is the high byte, Q the low byte.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] q);
        return (2*W)'(int'(a) * 256 + int'(q));
    endfunction

    logic [2*W-1:0] exp_p;
    logic [W-1:0]   av [8];
    logic [W-1:0]   qv [8];
    int             base_a, base_q;
    bit             b2b;

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0;
        a_val = '0; q_val = '0;
        repeat (2) step();
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_oe", {oe_a, oe_q}, 0);
        check("rst_prod", {prod_neg, prod}, 0);
        rst = 1'b0;
        step();

        // 1. Basic read, latency and strobe order
        a_val = 8'hF3; q_val = 8'h28; exp_p = model(a_val, q_val);
        start = 1'b1; step(); start = 1'b0;
        check("t1_drva_oe", {oe_a, oe_q}, 2'b10);
        check("t1_drva_busy", {busy, valid}, 2'b10);
        step();
        check("t1_drvq_oe", {oe_a, oe_q}, 2'b01);
        check("t1_drvq_valid", valid, 0);
        step();
        check("t1_valid", valid, 1);
        check("t1_prod", prod, exp_p);
        check("t1_neg", prod_neg, 1);
        check("t1_oe_idle", {oe_a, oe_q}, 0);
        ready = 1'b1; step(); ready = 1'b0;
        check("t1_hs_valid", valid, 0);
        check("t1_hs_busy", busy, 0);

        // 2. Backpressure
        a_val = 8'h00; q_val = 8'hC8; exp_p = model(a_val, q_val);
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", valid, 1);
            check("t2_hold_prod", {prod_neg, prod}, {1'b0, exp_p});
            check("t2_hold_oe", {oe_a, oe_q}, 0);
            step();
        end
        ready = 1'b1; step(); ready = 1'b0;
        check("t2_drop_valid", valid, 0);
        check("t2_prod_kept", prod, exp_p);

        // 3. Back-to-back
        a_val = W'($urandom); q_val = W'($urandom);
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("t3_first", prod, model(a_val, q_val));
        ready = 1'b1; start = 1'b1;
        step();
        ready = 1'b0; start = 1'b0;
        a_val = 8'h7F; q_val = 8'hFF;
        check("t3_b2b_drva", {oe_a, oe_q, valid, busy}, 4'b1001);
        step(); step();
        check("t3_valid", valid, 1);
        check("t3_prod", prod, 16'h7FFF);
        check("t3_neg", prod_neg, 0);
        ready = 1'b1; step(); ready = 1'b0;

        // 4. Ignored starts
        base_a = oe_a_cnt; base_q = oe_q_cnt;
        a_val = 8'h81; q_val = 8'h3C; exp_p = model(a_val, q_val);
        start = 1'b1; step(); start = 1'b0;   // DRV_A
        step();                                // DRV_Q
        start = 1'b1; step(); start = 1'b0;   // into OUT, start ignored
        check("t4_out", valid, 1);
        start = 1'b1; step(); start = 1'b0;   // OUT without ready, ignored
        step();
        check("t4_still_out", {valid, oe_a, oe_q}, 3'b100);
        check("t4_prod", prod, exp_p);
        ready = 1'b1; step(); ready = 1'b0;
        repeat (3) step();
        check("t4_busy", busy, 0);
        check("t4_oe_a_once", oe_a_cnt - base_a, 1);
        check("t4_oe_q_once", oe_q_cnt - base_q, 1);

        // 5. Async reset mid-operation
        a_val = 8'h55; q_val = 8'hAA;
        start = 1'b1; step(); start = 1'b0;   // DRV_A, prod still holds 0x813C
        check("t5_in_drva", oe_a, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_oe_async", {oe_a, oe_q}, 0);
        check("t5_valid", {valid, busy}, 0);
        check("t5_prod", {prod_neg, prod}, 0);
        #3 rst = 1'b0;
        step(); step();
        check("t5_stay_idle", {oe_a, oe_q, valid, busy}, 0);

        // 6. Randomised products with random backpressure and chaining
        for (int i = 0; i < 8; i++) begin
            av[i] = W'($urandom); qv[i] = W'($urandom);
        end
        b2b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_val = av[i]; q_val = qv[i];
            if (!b2b) begin
                start = 1'b1; step(); start = 1'b0;
            end
            check("r_drva", {oe_a, oe_q}, 2'b10);
            step(); step();
            check("r_valid", valid, 1);
            check("r_prod", {prod_neg, prod}, {av[i][W-1], model(av[i], qv[i])});
            repeat ($urandom_range(0, 3)) begin
                step();
                check("r_hold", prod, model(av[i], qv[i]));
            end
            b2b = (i < 7) && ($urandom_range(0, 1) == 1);
            ready = 1'b1; start = b2b;
            step();
            ready = 1'b0; start = 1'b0;
            check("r_hs", valid, 0);
            if (!b2b) check("r_idle", busy, 0);
        end

        check("no_contention", contention_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
